pk_vault_ctrl: RTL

Parametrised second-generation controller for the password-keeper hardware wrapper. It boots the CAM from flash for a configurable number of stored entries, then serves lookup and store requests. On a hit it decrypts the stored password and re-encrypts it under the local master key. On a miss it encrypts the new password and appends it to flash and CAM. Compared with the first-generation FSM, it adds configurable depth, a registered entry counter with a full flag, a lookup-only mode, a configurable CAM latency, engine time-outs and an error code.

---
 rtl/pk_vault_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pk_vault_ctrl.sv
// Password-keeper controller: boots the CAM from flash, then serves lookup/store requests.
// Moore outputs decoded from state; engines and CAM are waited on with bounded counters, no backpressure.
module pk_vault_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int CAM_LAT = 1,
    parameter int TMO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              op,
    input  logic [ADDR_W:0]   boot_cnt,
    input  logic              match,
    input  logic [ADDR_W-1:0] match_addr,
    input  logic              enc_done,
    input  logic              dec_done,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              cam_start,
    output logic              cam_write_en,
    output logic              flash_write_en,
    output logic              start_enc,
    output logic              start_dec,
    output logic              flash_or_acc_sel,
    output logic              flash_or_acc_reg,
    output logic              pass_enc_reg,
    output logic              plain_reg,
    output logic              flash_pass_reg,
    output logic              local_master_sel,
    output logic              local_master_reg,
    output logic              out_reg,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]    DEPTH_C  = CW'(DEPTH);
    localparam logic [3:0]       CAM_LAST = 4'(CAM_LAT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [4:0] {
        RST_ST, BOOT_CHK, BOOT_LOAD, BOOT_NEXT, IDLE, LOOKUP, CAM_WAIT,
        HIT, DEC_START, DEC_WAIT, ENC_M, ENC_M_WAIT,
        MISS, ENC_N, ENC_N_WAIT, WRITE, OUT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    // Address is one bit wider than the port so boot can count up to a full 2^ADDR_W table.
    logic [CW-1:0]     r_addr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_err;
    logic              r_op;
    logic [3:0]        r_cam_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              w_err_ld;
    logic [1:0]        w_err_val;
    logic              w_full;
    logic              w_cam_last;
    logic              w_tmo_last;
    logic [CW-1:0]     w_boot_n;

    assign w_boot_n   = (boot_cnt > DEPTH_C) ? DEPTH_C : boot_cnt;
    assign w_full     = (r_count == DEPTH_C);
    assign w_cam_last = (r_cam_cnt == CAM_LAST);
    // Leaving after the last count value means the engine got 2^TMO_W-1 cycles.
    assign w_tmo_last = (r_tmo == TMO_LAST);

    assign addr  = r_addr[ADDR_W-1:0];
    assign count = r_count;
    assign full  = w_full;
    assign err   = r_err;

    always_comb begin
        w_next    = r_state;
        w_err_ld  = 1'b0;
        w_err_val = 2'd0;
        case (r_state)
            RST_ST:    w_next = BOOT_CHK;
            BOOT_CHK:  w_next = (r_addr < r_count) ? BOOT_LOAD : IDLE;
            BOOT_LOAD: w_next = BOOT_NEXT;
            BOOT_NEXT: w_next = BOOT_CHK;
            IDLE:      if (go) w_next = LOOKUP;
            LOOKUP:    w_next = CAM_WAIT;
            CAM_WAIT: begin
                if (w_cam_last) begin
                    if (match) begin
                        w_next = HIT;
                    end else if (r_op) begin
                        w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd1;
                    end else if (w_full) begin
                        w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd2;
                    end else begin
                        w_next = MISS;
                    end
                end
            end
            HIT:       w_next = DEC_START;
            DEC_START: w_next = DEC_WAIT;
            DEC_WAIT: begin
                if (dec_done) begin
                    w_next = ENC_M;
                end else if (w_tmo_last) begin
                    w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd3;
                end
            end
            ENC_M:     w_next = ENC_M_WAIT;
            ENC_M_WAIT: begin
                if (enc_done) begin
                    w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd0;
                end else if (w_tmo_last) begin
                    w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd3;
                end
            end
            MISS:      w_next = ENC_N;
            ENC_N:     w_next = ENC_N_WAIT;
            ENC_N_WAIT: begin
                if (enc_done) begin
                    w_next = WRITE;
                end else if (w_tmo_last) begin
                    w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd3;
                end
            end
            WRITE: begin
                w_next = OUT; w_err_ld = 1'b1; w_err_val = 2'd0;
            end
            OUT:       w_next = IDLE;
            default:   w_next = RST_ST;
        endcase
    end

    always_comb begin
        cam_start        = 1'b0;
        cam_write_en     = 1'b0;
        flash_write_en   = 1'b0;
        start_enc        = 1'b0;
        start_dec        = 1'b0;
        flash_or_acc_sel = 1'b0;
        flash_or_acc_reg = 1'b0;
        pass_enc_reg     = 1'b0;
        plain_reg        = 1'b0;
        flash_pass_reg   = 1'b0;
        local_master_sel = 1'b0;
        local_master_reg = 1'b0;
        out_reg          = 1'b0;
        done             = 1'b0;
        busy             = (r_state != IDLE) && (r_state != RST_ST);
        case (r_state)
            BOOT_LOAD:  begin cam_write_en = 1'b1; flash_or_acc_reg = 1'b1; end
            LOOKUP:     begin flash_or_acc_sel = 1'b1; flash_or_acc_reg = 1'b1; end
            CAM_WAIT:   cam_start = (r_cam_cnt == 4'd0);
            HIT:        pass_enc_reg = 1'b1;
            DEC_START:  start_dec = 1'b1;
            DEC_WAIT:   plain_reg = 1'b1;
            ENC_M:      begin start_enc = 1'b1; local_master_sel = 1'b1; local_master_reg = 1'b1; end
            MISS:       begin plain_reg = 1'b1; local_master_reg = 1'b1; end
            ENC_N:      start_enc = 1'b1;
            ENC_N_WAIT: flash_pass_reg = 1'b1;
            WRITE:      begin flash_write_en = 1'b1; cam_write_en = 1'b1; flash_or_acc_reg = 1'b1; end
            OUT:        begin out_reg = 1'b1; done = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_ST;
            r_addr    <= '0;
            r_count   <= '0;
            r_err     <= 2'd0;
            r_op      <= 1'b0;
            r_cam_cnt <= 4'd0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_next;
            if (w_err_ld) r_err <= w_err_val;
            r_cam_cnt <= (r_state == CAM_WAIT) ? r_cam_cnt + 4'd1 : 4'd0;
            // Any state change clears the time-out count, so each wait state starts from zero.
            r_tmo     <= (w_next == r_state) ? r_tmo + 1'b1 : '0;
            case (r_state)
                RST_ST: begin
                    r_count <= w_boot_n;
                    r_addr  <= '0;
                end
                BOOT_CHK:  if (w_next == IDLE) r_addr <= '0;
                BOOT_NEXT: r_addr <= r_addr + 1'b1;
                IDLE:      if (go) r_op <= op;
                CAM_WAIT: begin
                    if (w_next == HIT)       r_addr <= CW'(match_addr);
                    else if (w_next == MISS) r_addr <= r_count;
                end
                WRITE:     if (!w_full) r_count <= r_count + 1'b1;
                default:   ;
            endcase
        end
    end
endmodule
